// File: rtl/vit_pkg.sv
// Shared definitions for the Viterbi decoder blocks:
// log2 helper, best-state FSM encoding, default metric width.
package vit_pkg;

    localparam int VIT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } vit_state_e;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= v) return r;
        end
        return 31;
    endfunction

endpackage

// File: rtl/vit_best_state_search_if.sv
// Handshake bundle for the best-state search: metric vector in
// (in_valid/in_ready/metrics), result out (out_valid/out_ready/results).
// slave: the search block; master: the producer/consumer side.
interface vit_best_state_search_if
    import vit_pkg::*;
#(
    parameter int W  = VIT_W,
    parameter int NS = 8
) ();

    localparam int SW = clog2(NS);

    logic            in_valid;
    logic            in_ready;
    logic [NS*W-1:0] metrics;
    logic            out_valid;
    logic            out_ready;
    logic [SW-1:0]   best_state;
    logic [W-1:0]    min_metric;
    logic            norm_flag;

    modport slave (
        input  in_valid, metrics, out_ready,
        output in_ready, out_valid, best_state, min_metric, norm_flag
    );

    modport master (
        output in_valid, metrics, out_ready,
        input  in_ready, out_valid, best_state, min_metric, norm_flag
    );

endinterface

// File: rtl/vit_lane_min.sv
// Combinational minimum over LANES unsigned metrics.
// Ports: vals (packed lanes, lane i at [i*W +: W]), min_val, min_idx (lowest lane on ties).
module vit_lane_min
    import vit_pkg::*;
#(
    parameter  int W     = VIT_W,
    parameter  int LANES = 2,
    localparam int LW    = (LANES > 1) ? clog2(LANES) : 1
) (
    input  logic [LANES*W-1:0] vals,
    output logic [W-1:0]       min_val,
    output logic [LW-1:0]      min_idx
);

    // Strict less-than keeps the earlier lane on equal values.
    always_comb begin
        min_val = vals[W-1:0];
        min_idx = '0;
        for (int i = 1; i < LANES; i++) begin
            if (vals[i*W +: W] < min_val) begin
                min_val = vals[i*W +: W];
                min_idx = LW'(i);
            end
        end
    end

endmodule

// File: rtl/vit_best_state_search.sv
// Sequential traceback start-state search: scans NS metrics LANES per clock,
// returns index and value of the minimum (lowest index wins ties).
// Ports: clk, reset (async, active-high), bus (slave handshake bundle).
// Optional VIT_BSS_NORM_EN: norm_flag = (min_metric >= NORM_THRESH), else tied 0.
module vit_best_state_search
    import vit_pkg::*;
#(
    parameter int W           = VIT_W,
    parameter int NS          = 8,
    parameter int LANES       = 2,
    parameter int NORM_THRESH = 2 ** (W - 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    vit_best_state_search_if.slave   bus
);

    localparam int C  = NS / LANES;
    localparam int SW = clog2(NS);
    localparam int CW = (C > 1) ? clog2(C) : 1;
    localparam int LW = (LANES > 1) ? clog2(LANES) : 1;

    vit_state_e          state;
    logic [NS*W-1:0]     cap;
    logic [CW-1:0]       cnt;
    logic [W-1:0]        run_min;
    logic [SW-1:0]       run_idx;

    logic [LANES*W-1:0]  chunk;
    logic [W-1:0]        lane_val;
    logic [LW-1:0]       lane_idx;
    logic [SW-1:0]       cand_idx;
    logic                take;
    logic                last;
    logic [W-1:0]        nxt_min;
    logic [SW-1:0]       nxt_idx;

    assign chunk = cap[cnt*(LANES*W) +: LANES*W];

    vit_lane_min #(
        .W     (W),
        .LANES (LANES)
    ) u_lane_min (
        .vals    (chunk),
        .min_val (lane_val),
        .min_idx (lane_idx)
    );

    // Global state index = chunk number concatenated with lane index.
    if (C == 1) begin : g_idx_one
        assign cand_idx = SW'(lane_idx);
    end else if (LANES == 1) begin : g_idx_lane1
        logic unused_lane_idx;
        assign unused_lane_idx = ^lane_idx;
        assign cand_idx = SW'(cnt);
    end else begin : g_idx_cat
        assign cand_idx = {cnt, lane_idx};
    end

    // Chunk 0 seeds the running best; later chunks win only if strictly smaller.
    assign take    = (cnt == '0) || (lane_val < run_min);
    assign last    = (cnt == CW'(C - 1));
    assign nxt_min = take ? lane_val : run_min;
    assign nxt_idx = take ? cand_idx : run_idx;

    assign bus.in_ready = (state == IDLE) && !reset;

`ifndef VIT_BSS_NORM_EN
    logic unused_thresh;
    assign unused_thresh = ^NORM_THRESH;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cap            <= '0;
            cnt            <= '0;
            run_min        <= '0;
            run_idx        <= '0;
            bus.out_valid  <= 1'b0;
            bus.best_state <= '0;
            bus.min_metric <= '0;
            bus.norm_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        cap   <= bus.metrics;
                        cnt   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    run_min <= nxt_min;
                    run_idx <= nxt_idx;
                    if (last) begin
                        cnt            <= '0;
                        bus.best_state <= nxt_idx;
                        bus.min_metric <= nxt_min;
`ifdef VIT_BSS_NORM_EN
                        bus.norm_flag  <= (nxt_min >= W'(NORM_THRESH));
`else
                        bus.norm_flag  <= 1'b0;
`endif
                        bus.out_valid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vit_best_state_search.sv
// Directed bench for vit_best_state_search with a reference minimum model
// and literal pins on the documented vectors.
module tb_vit_best_state_search;
    import vit_pkg::*;

    localparam int W     = 8;
    localparam int NS    = 8;
    localparam int LANES = 2;
    localparam int C     = NS / LANES;

`ifdef VIT_BSS_NORM_EN
    localparam bit NORM_ON = 1'b1;
`else
    localparam bit NORM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vit_best_state_search_if #(.W(W), .NS(NS)) bus ();

    vit_best_state_search #(
        .W           (W),
        .NS          (NS),
        .LANES       (LANES),
        .NORM_THRESH (128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int exp_idx;
    int exp_min;
    int exp_norm;
    int lat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain first-minimum search over the whole vector.
    function automatic void model(input int v[NS]);
        int mn;
        int idx;
        mn  = v[0];
        idx = 0;
        for (int s = 1; s < NS; s++) begin
            if (v[s] < mn) begin
                mn  = v[s];
                idx = s;
            end
        end
        exp_idx  = idx;
        exp_min  = mn;
        exp_norm = (NORM_ON && mn >= 128) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (!reset && bus.out_valid) begin
            chk("cmp_best_state", int'(bus.best_state), exp_idx);
            chk("cmp_min_metric", int'(bus.min_metric), exp_min);
            chk("cmp_norm_flag", int'(bus.norm_flag), exp_norm);
        end
    end

    task automatic accept(input int v[NS]);
        logic [NS*W-1:0] p;
        int n;
        for (int s = 0; s < NS; s++) p[s*W +: W] = W'(v[s]);
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
        model(v);
        bus.metrics  = p;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!bus.out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("ack_out_valid", int'(bus.out_valid), 0);
        chk("ack_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.metrics   = '0;
        exp_idx = 0; exp_min = 0; exp_norm = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_best_state", int'(bus.best_state), 0);
        chk("rst_min_metric", int'(bus.min_metric), 0);
        chk("rst_norm_flag", int'(bus.norm_flag), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 1);

        accept('{10, 20, 30, 5, 40, 50, 60, 70});
        chk("busy_in_ready", int'(bus.in_ready), 0);
        wait_out(lat);
        chk("latency", lat, C);
        chk("lit1_best", int'(bus.best_state), 3);
        chk("lit1_min", int'(bus.min_metric), 5);
        ack();

        accept('{7, 7, 7, 7, 7, 7, 7, 7});
        wait_out(lat);
        chk("lit_all7_best", int'(bus.best_state), 0);
        ack();

        accept('{9, 9, 3, 9, 9, 3, 9, 9});
        wait_out(lat);
        chk("lit_tie_best", int'(bus.best_state), 2);
        ack();

        accept('{255, 255, 255, 255, 255, 255, 255, 254});
        wait_out(lat);
        chk("lit_max_best", int'(bus.best_state), 7);
        chk("lit_max_min", int'(bus.min_metric), 254);
        ack();

        // Hold result while a new vector is offered; it must be ignored.
        accept('{50, 40, 30, 20, 10, 60, 70, 80});
        wait_out(lat);
        bus.metrics  = '0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_out_valid", int'(bus.out_valid), 1);
            chk("stall_best", int'(bus.best_state), 4);
            chk("stall_min", int'(bus.min_metric), 10);
        end
        bus.in_valid = 1'b0;
        ack();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_out_valid", int'(bus.out_valid), 0);
        end

        // Reset between chunk 1 and chunk 2 of a scan.
        accept('{30, 31, 32, 33, 34, 35, 36, 37});
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_best", int'(bus.best_state), 0);
        chk("mid_rst_min", int'(bus.min_metric), 0);
        chk("mid_rst_norm", int'(bus.norm_flag), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_result", int'(bus.out_valid), 0);
        end

        accept('{1, 2, 3, 4, 5, 6, 7, 8});
        wait_out(lat);
        chk("post_rst_latency", lat, C);
        chk("post_rst_best", int'(bus.best_state), 0);
        chk("post_rst_min", int'(bus.min_metric), 1);
        ack();

        accept('{250, 250, 250, 250, 250, 200, 250, 250});
        wait_out(lat);
        chk("norm200_best", int'(bus.best_state), 5);
        chk("norm200_flag", int'(bus.norm_flag), NORM_ON ? 1 : 0);
        ack();

        accept('{200, 200, 200, 200, 200, 200, 127, 200});
        wait_out(lat);
        chk("norm127_best", int'(bus.best_state), 6);
        chk("norm127_flag", int'(bus.norm_flag), 0);
        ack();

        // Back-to-back with out_ready held high: C+2 cycles per vector.
        bus.out_ready = 1'b1;
        accept('{60, 61, 62, 63, 64, 65, 66, 0});
        lat = 0;
        while (!bus.in_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("turnaround", lat + 1, C + 2);
        bus.out_ready = 1'b0;

        accept('{3, 2, 2, 3, 4, 1, 1, 9});
        wait_out(lat);
        chk("lit_last_best", int'(bus.best_state), 5);
        ack();

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vit_best_state_search.md
# vit_best_state_search

Sequential, parametrised traceback start-state search for the Viterbi decoders. It accepts one vector of NS accumulated path metrics through a valid/ready handshake and scans it LANES metrics per clock. It returns the index of the smallest metric (lowest index wins ties) together with that minimum. It sits between the ACS/path-metric memory and the traceback unit, and replaces the fixed 8-state combinational decision for any code rate and constraint length.

## Interface
- W, 8: path-metric width, unsigned, bits.
- NS, 8: number of trellis states; power of two, ≥2.
- LANES, 2: metrics compared per clock; power of two, divides NS, ≤NS.
- NORM_THRESH, 2**(W-1): normalisation threshold; used only with VIT_BSS_NORM_EN.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  metric vector valid.
- in_ready  out  1  block can accept a vector.
- metrics  in  NS*W  state s occupies bits [s*W +: W].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- best_state  out  clog2(NS)  index of the minimum metric.
- min_metric  out  W  value of the minimum metric.
- norm_flag  out  1  minimum is ≥ NORM_THRESH; constant 0 without the macro.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture metrics into an internal register, clear chunk counter to 0, go to SCAN.
  - SCAN: each cycle, the lane-min of chunk k (states k*LANES .. k*LANES+LANES-1) is compared with the running best. After the last chunk (k=C-1, where C=NS/LANES), load result registers and go to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE.
- in_ready is 0 in SCAN and DONE. Input changes there are ignored; the captured copy is used.
- Compare rule is unsigned. A candidate replaces the running best only if strictly smaller, so the earliest (lowest) index wins on ties, both within and across chunks.
- Chunk 0 initialises the running best unconditionally; no sentinel value is used.
- Chunk counter is clog2(C) bits, or 1 bit when C=1. It does not wrap; leaving SCAN resets it.
- Reset in any state: FSM→IDLE, in_ready=1 once reset deasserts, out_valid=0, best_state=0, min_metric=0, norm_flag=0, counter=0. Any scan in progress is discarded.

## Timing
- Acceptance edge E0. out_valid rises after edge E0+C (latency C cycles; 4 for defaults).
- Minimum cycle from one acceptance to the next is C+2, with out_ready held high.
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output except in_ready, which is a state decode.
- C=1 (LANES=NS): one SCAN cycle, latency 1.

## Configuration
- VIT_BSS_NORM_EN defined:
  - norm_flag is registered with the result as (min_metric ≥ NORM_THRESH).
  - The ACS controller uses it to subtract min_metric from all metrics.
- Undefined: the comparator is not built and norm_flag is tied to 0. The port remains, so the instantiation is identical in both builds.

## Structure
- Package vit_pkg holds:
  - the clog2 constant function;
  - the FSM state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2);
  - the shared metric-width default.
- Sub-module vit_lane_min: combinational LANES-input minimum tree returning the value and a local index, lowest index on ties. It is instantiated once and fed by a chunk mux.

## Test plan
Defaults: W=8, NS=8, LANES=2.
- Metrics [10,20,30,5,40,50,60,70] (state 0..7) → best_state=3, min_metric=5, out_valid exactly 4 cycles after accept.
- All metrics 7 → best_state=0. Metrics [9,9,3,9,9,3,9,9] → best_state=2 (cross-chunk tie).
- All 255 except state 7=254 → best_state=7, min_metric=254 (no overflow at max value).
- out_ready low for 10 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored. out_ready pulse → IDLE, in_ready=1 the next cycle.
- Reset asserted during SCAN chunk 2 → all outputs 0 immediately, IDLE after release. A following vector [1..8] → best_state=0, min_metric=1.
- With VIT_BSS_NORM_EN and NORM_THRESH=128: min 200 → norm_flag=1, min 127 → 0. Without the macro, norm_flag is always 0.
